mux2_arbiter: RTL and testbench



---
 rtl/mux2_arbiter_pkg.sv | 23 ++
 rtl/mux2_arbiter_bus.sv | 13 +
 rtl/mux2_arbiter.sv | 82 ++++++++
 tb/tb_mux2_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mux2_arbiter_pkg.sv
// State encodings and the shared arbitration rule for mux2_arbiter.
// Both IDLE entry and release-time re-arbitration use arbitrate().
package mux2_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // A lone requester wins; a tie goes to the priority pointer.
    function automatic state_t arbitrate(input logic r0, input logic r1, input logic p);
        if (r0 && r1)
            return p ? OWN1 : OWN0;
        else if (r0)
            return OWN0;
        else if (r1)
            return OWN1;
        else
            return IDLE;
    endfunction

endpackage

// File: rtl/mux2_arbiter_bus.sv
// Plain 2:1 mux for the shared datapath: combinational, no latency, no flow control.
module mux2_bus #(
    parameter int W = 9
) (
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic         sel,
    output logic [W-1:0] y
);

    assign y = sel ? in1 : in0;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin burst arbiter sharing one 2:1 mux; grant appears 1 cycle after a request in IDLE.
// Datapath is combinational through registered sel/state; stalls hold grant and count.
module mux2_arbiter
    import mux2_arbiter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             last0,
    input  logic             last1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready
);

    localparam int CW = $clog2(MAX_BURST + 1);

    state_t          state;
    state_t          next_own;
    logic            ptr;
    logic [CW-1:0]   cnt;
    logic [WIDTH:0]  mux_y;
    logic            owner;
    logic            beat;
    logic            rls;
    logic            take;

    mux2_bus #(
        .W(WIDTH + 1)
    ) u_bus (
        .in0 ({last0, data0}),
        .in1 ({last1, data1}),
        .sel (sel),
        .y   (mux_y)
    );

    assign owner     = (state == OWN1);
    assign out_valid = ((state == OWN0) && req0) || ((state == OWN1) && req1);
    assign out_data  = mux_y[WIDTH-1:0];
    assign out_last  = (state != IDLE) && mux_y[WIDTH];
    assign gnt0      = (state == OWN0) && req0 && out_ready;
    assign gnt1      = (state == OWN1) && req1 && out_ready;

    assign beat = out_valid && out_ready;
    assign rls  = beat && (out_last || (cnt == CW'(MAX_BURST - 1)));
    assign take = (state == IDLE) || rls;

    // On release the pointer flips first, so the other requester wins a tie this same cycle.
    assign next_own = arbitrate(req0, req1, rls ? ~owner : ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 1'b0;
            cnt   <= '0;
            sel   <= 1'b0;
        end else begin
            if (take) begin
                state <= next_own;
                if (next_own != IDLE)
                    sel <= (next_own == OWN1);
            end
            if (rls) begin
                ptr <= ~owner;
                cnt <= '0;
            end else if (beat) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Randomised and directed bench for mux2_arbiter against a burst-level reference model.
module tb_mux2_arbiter;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0, req1, last0, last1, out_ready;
    logic [WIDTH-1:0] data0, data1;
    logic             gnt0, gnt1, sel, out_valid, out_last;
    logic [WIDTH-1:0] out_data;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the mux (-1 = nobody), whose turn is next on a tie,
    // beats delivered in the current grant, and the last requester selected.
    int m_owner, m_ptr, m_beats, m_sel;

    always #5 clk = ~clk;

    mux2_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .data0    (data0),
        .data1    (data1),
        .last0    (last0),
        .last1    (last1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .sel      (sel),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic r0, input logic r1, input int turn);
        if (r0 && r1) return turn;
        if (r0)       return 0;
        if (r1)       return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
        m_sel   = 0;
    endtask

    function automatic logic req_of(input int who);
        return (who == 0) ? req0 : req1;
    endfunction

    task automatic check_outputs();
        logic             ev, el, eg0, eg1;
        logic [WIDTH-1:0] ed;
        ev  = (m_owner >= 0) && req_of(m_owner);
        el  = (m_owner == 0) ? last0 : (m_owner == 1) ? last1 : 1'b0;
        ed  = (m_sel == 0) ? data0 : data1;
        eg0 = (m_owner == 0) && req0 && out_ready;
        eg1 = (m_owner == 1) && req1 && out_ready;
        chk("gnt0", gnt0, eg0);
        chk("gnt1", gnt1, eg1);
        chk("sel", sel, m_sel[0]);
        chk("out_valid", out_valid, ev);
        chk("out_last", out_last, el);
        chk("out_data", out_data, ed);
    endtask

    task automatic model_step();
        int  w;
        logic lst;
        if (m_owner < 0) begin
            w = pick(req0, req1, m_ptr);
            m_owner = w;
            if (w >= 0) m_sel = w;
        end else if (req_of(m_owner) && out_ready) begin
            m_beats++;
            lst = (m_owner == 0) ? last0 : last1;
            if (lst || m_beats == MAX_BURST) begin
                m_ptr   = 1 - m_owner;
                m_beats = 0;
                w = pick(req0, req1, m_ptr);
                m_owner = w;
                if (w >= 0) m_sel = w;
            end
        end
    endtask

    // Drive one cycle of inputs just after a rising edge, check mid-cycle, advance the model.
    task automatic step(input logic r, input logic r0, input logic r1,
                        input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                        input logic l0, input logic l1, input logic ordy);
        rst_n = r; req0 = r0; req1 = r1; data0 = d0; data1 = d1;
        last0 = l0; last1 = l1; out_ready = ordy;
        if (!rst_n) model_reset();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    function automatic logic [WIDTH-1:0] rd();
        return WIDTH'($urandom);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    initial begin
        model_reset();
        rst_n = 1'b0;
        req0 = 0; req1 = 0; last0 = 0; last1 = 0; out_ready = 0;
        data0 = '0; data1 = '0;

        // Reset held with random inputs.
        for (int i = 0; i < 3; i++)
            step(0, rb(), rb(), rd(), rd(), rb(), rb(), rb());

        // Only req1 out of reset; finish its burst with last.
        step(1, 0, 1, rd(), rd(), 0, 0, 1);
        step(1, 0, 1, rd(), rd(), 0, 0, 1);
        step(1, 0, 1, rd(), rd(), 0, 1, 1);
        step(1, 0, 0, rd(), rd(), 0, 0, 1);

        // Three-beat burst from requester 0, last on beat 3.
        step(1, 1, 0, rd(), rd(), 0, 0, 1);
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, rd(), rd(), (i == 2), 0, 1);
        step(1, 0, 0, rd(), rd(), 0, 0, 1);

        // Both requesting continuously with no last: forced alternation.
        for (int i = 0; i < 20; i++)
            step(1, 1, 1, rd(), rd(), 0, 0, 1);

        // Backpressure 1,0,0,1 with stable source data.
        begin
            logic [WIDTH-1:0] h0, h1;
            h0 = rd(); h1 = rd();
            for (int i = 0; i < 16; i++) begin
                step(1, 1, 1, h0, h1, 0, 0, (i % 4 == 0) || (i % 4 == 3));
                if (gnt0) h0 = rd();
                if (gnt1) h1 = rd();
            end
        end

        // Granted requester gaps for two cycles while the other keeps requesting.
        for (int i = 0; i < 12; i++)
            step(1, !(i == 3 || i == 4), !(i == 8 || i == 9), rd(), rd(), 0, 0, 1);

        // Reset after beat 2 of a burst, then both request together.
        step(0, 0, 0, rd(), rd(), 0, 0, 1);
        step(1, 1, 0, rd(), rd(), 0, 0, 1);
        step(1, 1, 0, rd(), rd(), 0, 0, 1);
        step(1, 1, 0, rd(), rd(), 0, 0, 1);
        step(0, 1, 1, rd(), rd(), 0, 0, 1);
        step(0, 1, 1, rd(), rd(), 0, 0, 1);
        for (int i = 0; i < 6; i++)
            step(1, 1, 1, rd(), rd(), 0, 0, 1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 rd(), rd(),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) != 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
